// File: rtl/alien_sprite_drawer.sv
// alien_sprite_drawer: erases the previous alien rectangle and draws the sprite bitmap at the
// new position into the vga_adapter plot port, one pixel per clock.
module alien_sprite_drawer #(
    parameter int SPR_W = 8,
    parameter int SPR_H = 8,
    parameter logic [SPR_W*SPR_H-1:0] SPRITE = 64'h183C_7EDB_FF24_5AA5,
    parameter logic [2:0] FG_COLOUR = 3'b010,
    parameter logic [2:0] BG_COLOUR = 3'b000,
    parameter int SCR_W = 160,
    parameter int SCR_H = 120
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] pos_x,
    input  logic [6:0] pos_y,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy,
    output logic       frame_done
);
    typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;
    localparam logic [SPR_W*SPR_H-1:0] ONE = 1;
    state_t     state_q;
    logic [3:0] col_q, row_q;
    logic [7:0] new_x_q, last_x_q;
    logic [6:0] new_y_q, last_y_q;
    logic       first_q;
    logic [8:0] px_d, idx_d;
    logic [7:0] py_d;
    logic [2:0] colour_d;
    logic       col_last, row_last, vis_d;
    always_comb begin
        px_d     = {1'b0, state_q == ERASE ? last_x_q : new_x_q} + {5'b0, col_q};
        py_d     = {1'b0, state_q == ERASE ? last_y_q : new_y_q} + {4'b0, row_q};
        idx_d    = 9'({5'b0, row_q} * 9'(SPR_W)) + {5'b0, col_q};
        colour_d = (state_q == DRAW && |(SPRITE & (ONE << idx_d))) ? FG_COLOUR : BG_COLOUR;
        vis_d    = (px_d < 9'(SCR_W)) && (py_d < 8'(SCR_H));
        col_last = col_q == 4'(SPR_W - 1);
        row_last = row_q == 4'(SPR_H - 1);
    end
    assign busy       = (state_q == ERASE) || (state_q == DRAW);
    assign frame_done = state_q == DONE;
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            col_q      <= '0;
            row_q      <= '0;
            new_x_q    <= '0;
            new_y_q    <= '0;
            last_x_q   <= '0;
            last_y_q   <= '0;
            first_q    <= 1'b1;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
        end else begin
            vga_plot <= 1'b0;
            case (state_q)
                IDLE: if (first_q || {pos_x, pos_y} != {last_x_q, last_y_q}) begin
                    new_x_q <= pos_x;
                    new_y_q <= pos_y;
                    col_q   <= '0;
                    row_q   <= '0;
                    state_q <= first_q ? DRAW : ERASE;
                end
                ERASE, DRAW: begin
                    // clipped pixels still take their cycle, only the write is suppressed
                    vga_x      <= px_d[7:0];
                    vga_y      <= py_d[6:0];
                    vga_colour <= colour_d;
                    vga_plot   <= vis_d;
                    col_q      <= col_last ? 4'd0 : col_q + 4'd1;
                    if (col_last) begin
                        row_q <= row_last ? 4'd0 : row_q + 4'd1;
                        if (row_last) state_q <= state_q == ERASE ? DRAW : DONE;
                    end
                end
                default: begin
                    last_x_q <= new_x_q;
                    last_y_q <= new_y_q;
                    first_q  <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alien_sprite_drawer.sv
// tb_alien_sprite_drawer: scoreboard bench; expected pixels are queued when a position is
// driven and popped as the DUT plots them.
module tb_alien_sprite_drawer;
    localparam logic [63:0] SPR = 64'h183C_7EDB_FF24_5AA5;
    logic       clk = 1'b0, resetn = 1'b0;
    logic [7:0] pos_x = 8'd18;
    logic [6:0] pos_y = 7'd15;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot, busy, frame_done;
    logic [17:0] q[$];
    logic [17:0] exp_px;
    int checks = 0, errors = 0, plots = 0, busy_cyc = 0, fd_cnt = 0;

    alien_sprite_drawer #(.SPR_W(8), .SPR_H(8), .SPRITE(SPR), .FG_COLOUR(3'b010),
        .BG_COLOUR(3'b000), .SCR_W(160), .SCR_H(120)) dut (
        .clk(clk), .resetn(resetn), .pos_x(pos_x), .pos_y(pos_y), .vga_x(vga_x),
        .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot), .busy(busy),
        .frame_done(frame_done));

    always #5 clk = ~clk;

    always @(negedge clk) if (resetn) begin
        if (vga_plot) begin
            plots++;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_plot: got (%0d,%0d) c=%0d, required no plot", vga_x, vga_y, vga_colour);
            end else begin
                exp_px = q.pop_front();
                if ({vga_x, vga_y, vga_colour} !== exp_px) begin
                    errors++;
                    $display("FAIL pixel: got (%0d,%0d) c=%0d, required (%0d,%0d) c=%0d",
                             vga_x, vga_y, vga_colour, exp_px[17:10], exp_px[9:3], exp_px[2:0]);
                end
            end
        end
        if (busy) busy_cyc++;
        if (frame_done) fd_cnt++;
    end

    task automatic push_rect(input int x, input int y, input bit erase);
        logic [63:0] s = SPR;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                if (x + c < 160 && y + r < 120)
                    q.push_back({8'(x + c), 7'(y + r), (!erase && s[r*8+c]) ? 3'b010 : 3'b000});
    endtask

    task automatic clear_counts();
        plots = 0;
        busy_cyc = 0;
    endtask

    task automatic wait_frame(input int budget);
        int s = fd_cnt;
        int n = 0;
        while (fd_cnt == s && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (fd_cnt == s) begin
            errors++;
            $display("FAIL frame_timeout: got no frame_done in %0d cycles, required one", budget);
        end
    endtask

    task automatic check_counts(input string name, input int p, input int b, input int qs);
        checks++;
        if (plots !== p || busy_cyc !== b || q.size() !== qs) begin
            errors++;
            $display("FAIL %s: got plots=%0d busy=%0d queued=%0d, required plots=%0d busy=%0d queued=%0d",
                     name, plots, busy_cyc, q.size(), p, b, qs);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({vga_x, vga_y, vga_colour, vga_plot, busy, frame_done} !== 21'd0) begin
            errors++;
            $display("FAIL reset_outputs: got x=%0d y=%0d c=%0d plot=%b busy=%b fd=%b, required all 0",
                     vga_x, vga_y, vga_colour, vga_plot, busy, frame_done);
        end
    endtask

    task automatic test_first_draw();
        push_rect(18, 15, 0);
        clear_counts();
        fd_cnt = 0;
        @(posedge clk); #1 resetn = 1'b1;
        wait_frame(300);
        check_counts("first_draw", 64, 64, 0);
        repeat (5) @(posedge clk);
        checks++;
        if (fd_cnt !== 1) begin
            errors++;
            $display("FAIL first_done_pulses: got %0d, required 1", fd_cnt);
        end
    endtask

    task automatic test_idle_hold();
        clear_counts();
        repeat (500) @(posedge clk);
        #1;
        check_counts("idle_hold", 0, 0, 0);
    endtask

    task automatic test_step();
        clear_counts();
        push_rect(18, 15, 1);
        push_rect(19, 15, 0);
        pos_x = 8'd19;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || vga_plot !== 1'b0) begin
            errors++;
            $display("FAIL latency_c1: got busy=%b plot=%b, required busy=1 plot=0", busy, vga_plot);
        end
        @(negedge clk);
        checks++;
        if (vga_plot !== 1'b1) begin
            errors++;
            $display("FAIL latency_c2: got plot=%b, required 1", vga_plot);
        end
        repeat (80) @(posedge clk);
        #1 pos_x = 8'd20;
        repeat (10) @(posedge clk);
        #1 pos_x = 8'd21;
        push_rect(19, 15, 1);
        push_rect(21, 15, 0);
        wait_frame(400);
        check_counts("step", 128, 128, 128);
    endtask

    task automatic test_skip();
        clear_counts();
        wait_frame(400);
        check_counts("skip_latest", 128, 128, 0);
    endtask

    task automatic test_clip();
        clear_counts();
        push_rect(21, 15, 1);
        push_rect(156, 116, 0);
        pos_x = 8'd156;
        pos_y = 7'd116;
        wait_frame(400);
        check_counts("clip", 80, 128, 0);
    endtask

    task automatic test_reset_mid();
        int n = 0;
        push_rect(156, 116, 1);
        pos_x = 8'd60;
        pos_y = 7'd50;
        while (!busy && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL erase_start: got busy=%b, required 1", busy);
        end
        repeat (6) @(posedge clk);
        #1 resetn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (vga_plot !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: got plot=%b busy=%b, required 0 0", vga_plot, busy);
        end
        q.delete();
        push_rect(60, 50, 0);
        clear_counts();
        @(posedge clk); #1 resetn = 1'b1;
        wait_frame(300);
        check_counts("redraw_after_reset", 64, 64, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of run, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_first_draw();
        test_idle_hold();
        test_step();
        test_skip();
        test_clip();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
